// File: rtl/mux_scan_sampler.sv
// Scan controller for an 8:1 mux: walks the enabled channels in ascending order,
// dwells DWELL cycles on each, samples y into data_out[ch], then hands off the byte.
module mux_scan_sampler #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] chan_mask,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CW-1:0] LP_LAST = CW'(DWELL - 1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_ch, w_ch_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_mask, w_mask_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_busy;

  logic [2:0]    w_first_ch;
  logic [2:0]    w_next_ch;
  logic          w_has_next;

  // Priority searches: lowest set bit of the incoming mask, and lowest latched
  // channel strictly above the current one (no wrap-around).
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = r_ch;
    w_has_next = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (chan_mask[k]) w_first_ch = 3'(k);
      if (r_mask[k] && (k > int'(r_ch))) begin
        w_next_ch  = 3'(k);
        w_has_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (start && (chan_mask != 8'h00)) begin
          w_mask_nxt  = chan_mask;
          w_data_nxt  = 8'h00;
          w_ch_nxt    = w_first_ch;
          w_cnt_nxt   = '0;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (r_cnt == LP_LAST) begin
          w_data_nxt[r_ch] = y;
          w_cnt_nxt        = '0;
          if (w_has_next) begin
            w_ch_nxt = w_next_ch;
          end else begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign s0        = r_ch[0];
  assign s1        = r_ch[1];
  assign s2        = r_ch[2];
  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: a DWELL=4 instance driven from a vector table plus
// hand sequences, and a DWELL=1 instance for the single-cycle dwell corner.
module tb_mux_scan_sampler;

  localparam int DW = 4;

  logic clk, rst;
  // DWELL=4 instance
  logic       start, out_ready, y, s0, s1, s2, out_valid, busy;
  logic [7:0] chan_mask, mux_in, data_out;
  logic [2:0] sel;
  // DWELL=1 instance
  logic       start1, ready1, y1, s0_1, s1_1, s2_1, valid1, busy1;
  logic [7:0] mask1, mux1, data1;
  logic [2:0] sel1;

  int errors = 0;
  int checks = 0;

  assign sel  = {s2, s1, s0};
  assign sel1 = {s2_1, s1_1, s0_1};
  assign y    = mux_in[sel];
  assign y1   = mux1[sel1];

  mux_scan_sampler #(.DWELL(DW), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask), .y(y),
    .s0(s0), .s1(s1), .s2(s2), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  mux_scan_sampler #(.DWELL(1), .CW(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .chan_mask(mask1), .y(y1),
    .s0(s0_1), .s1(s1_1), .s2(s2_1), .data_out(data1), .out_valid(valid1),
    .out_ready(ready1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] mask;
    logic [7:0] mux;
    logic [7:0] exp_data;
    int         exp_lat;
    int         exp_last;
    int         hold;
    bit         disturb;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One scan on the DWELL=4 instance. hold = cycles of backpressure after out_valid;
  // disturb = pulse start (and scramble chan_mask) during SCAN, DONE and the handshake edge.
  task automatic run_scan(input vec_t v);
    int lat;
    bit seq_ok, stable_ok;
    int seq[$];
    seq = {};
    for (int k = 0; k < 8; k++)
      if (v.mask[k]) for (int d = 0; d < DW; d++) seq.push_back(k);
    chan_mask = v.mask;
    mux_in    = v.mux;
    out_ready = (v.hold == 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({v.name, " busy@accept"}, busy, 1);
    chk({v.name, " data cleared"}, data_out, 8'h00);
    lat = 0;
    seq_ok = 1'b1;
    while (!out_valid && lat < 300) begin
      if (lat < seq.size() && int'(sel) != seq[lat]) seq_ok = 1'b0;
      if (v.disturb && lat >= 2 && lat < 5) begin
        start = 1'b1;
        chan_mask = 8'hFF;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk({v.name, " latency"}, lat, v.exp_lat);
    chk({v.name, " select order"}, seq_ok, 1);
    chk({v.name, " data"}, data_out, v.exp_data);
    chk({v.name, " last sel"}, sel, v.exp_last);
    if (v.hold > 0) begin
      stable_ok = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        start = v.disturb;
        tick();
        if (!out_valid || data_out !== v.exp_data || int'(sel) != v.exp_last || !busy)
          stable_ok = 1'b0;
      end
      chk({v.name, " backpressure hold"}, stable_ok, 1);
    end
    out_ready = 1'b1;
    start = v.disturb;
    tick();
    start = 1'b0;
    chk({v.name, " valid drop"}, out_valid, 0);
    chk({v.name, " idle after hs"}, busy, 0);
    tick();
    chk({v.name, " no restart"}, busy, 0);
    out_ready = 1'b0;
  endtask

  // DWELL=1: y flips every cycle; phase picks whether even or odd channels read 1.
  task automatic run_dwell1(input bit phase, input logic [7:0] exp);
    int lat;
    bit seq_ok;
    mask1  = 8'hFF;
    mux1   = 8'h00;
    ready1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    seq_ok = 1'b1;
    while (!valid1 && lat < 50) begin
      if (int'(sel1) != lat) seq_ok = 1'b0;
      mux1 = (((lat % 2) == 0) ^ phase) ? 8'hFF : 8'h00;
      tick();
      lat++;
    end
    chk("dwell1 latency", lat, 8);
    chk("dwell1 one chan per cycle", seq_ok, 1);
    chk("dwell1 data", data1, exp);
    ready1 = 1'b1;
    tick();
    chk("dwell1 valid drop", valid1, 0);
    ready1 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"full",     8'hFF, 8'hA5, 8'hA5, 32, 7, 0,  1'b0};
    vecs[1] = '{"sparse",   8'h81, 8'hFF, 8'h81, 8,  7, 0,  1'b0};
    vecs[2] = '{"bkpr",     8'hFF, 8'hA5, 8'hA5, 32, 7, 10, 1'b1};
    vecs[3] = '{"disturb",  8'h81, 8'hFF, 8'h81, 8,  7, 0,  1'b1};
    vecs[4] = '{"mid4",     8'h3C, 8'hF0, 8'h30, 16, 5, 0,  1'b0};
    vecs[5] = '{"top1",     8'h80, 8'h80, 8'h80, 4,  7, 2,  1'b0};
    vecs[6] = '{"low4",     8'h0F, 8'h5A, 8'h0A, 16, 3, 0,  1'b0};
    vecs[7] = '{"alt",      8'h55, 8'hFF, 8'h55, 16, 6, 0,  1'b0};

    rst = 1'b1;
    start = 0; out_ready = 0; chan_mask = 0; mux_in = 0;
    start1 = 0; ready1 = 0; mask1 = 0; mux1 = 0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset valid", out_valid, 0);
    chk("reset data", data_out, 8'h00);
    chk("reset sel", sel, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // start with an empty mask is ignored
    chan_mask = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty mask busy", busy, 0);
    tick();
    chk("empty mask still idle", busy, 0);

    foreach (vecs[i]) run_scan(vecs[i]);

    // async reset in the middle of channel 3, off the clock edge
    chan_mask = 8'hFF;
    mux_in    = 8'hA5;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("pre-reset sel", sel, 3);
    chk("pre-reset partial data", data_out, 8'h05);
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst data", data_out, 8'h00);
    chk("async rst sel", sel, 0);
    chk("async rst valid", out_valid, 0);
    #2 rst = 1'b0;
    tick();
    run_scan(vecs[0]);

    run_dwell1(1'b0, 8'h55);
    tick();
    run_dwell1(1'b1, 8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
